inmultitor_secvential: RTL and testbench

//  Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH bits.

---
 rtl/inmultitor_secvential.sv | 110 +++++++++++
 tb/tb_inmultitor_secvential.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inmultitor_secvential.sv
// Sequential shift-and-add WIDTH x WIDTH unsigned multiplier feeding a 16-bit adder.
// Optional build macro INMULTITOR_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.

module sumator16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
endmodule

module inmultitor_secvential #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] sum;
  logic               sum_cout_unused;
  logic               last;

  // The product never exceeds 2*WIDTH bits, so the adder carry-out is dropped.
  sumator16 u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .cin (1'b0),
    .sum (sum),
    .cout(sum_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        last     = (cnt_q == CW'(WIDTH-1));
`ifdef INMULTITOR_EARLY_TERM_EN
        last     = last || (mplier_d == '0);
`endif
        if (last) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;
endmodule

// File: tb/tb_inmultitor_secvential.sv
// Self-checking bench for inmultitor_secvential: directed corner cases plus a randomized
// stream checked against an arithmetic reference (a*b, in-order queue).

module tb_inmultitor_secvential;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  inmultitor_secvential #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycles from the acceptance edge to out_valid, from the multiplier value alone.
  function automatic int exp_lat(input logic [7:0] mb);
`ifdef INMULTITOR_EARLY_TERM_EN
    if (mb == 8'h00) return 1;
    for (int i = 7; i >= 0; i--) if (mb[i]) return i + 1;
    return 1;
`else
    return (mb == mb) ? 8 : 8;
`endif
  endfunction

  // Wait for in_ready, present operands for one edge, then wait (bounded) for out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat(tb_v)));
    chk({tag, "_product"}, 32'(product), 32'(16'(ta) * 16'(tb_v)));
  endtask

  // One edge with out_ready high must hand off and return to IDLE.
  task automatic handoff(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q[$];
    int got_n, sent, cyc;
    logic [15:0] held;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);

    run_op(8'd13, 8'd11, "t1");
    handoff("t1");
    run_op(8'hFF, 8'hFF, "t2");
    handoff("t2");
    run_op(8'h5A, 8'h00, "t3");
    handoff("t3");

    // Back-pressure: DONE held, new operands ignored.
    out_ready = 1'b0;
    run_op(8'd7, 8'd9, "t4");
    held = product;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'(i + 1); b = 8'(i + 3);
      @(posedge clk);
      #1;
      chk("t4_hold_vld", 32'(out_valid), 32'd1);
      chk("t4_hold_prod", 32'(product), 32'd63);
      chk("t4_hold_rdy", 32'(in_ready), 32'd0);
    end
    chk("t4_held_same", 32'(product), 32'(held));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    handoff("t4");

    // Reset in the middle of a run.
    @(negedge clk);
    a = 8'd200; b = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("t5_running", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_rst_rdy", 32'(in_ready), 32'd1);
    chk("t5_rst_vld", 32'(out_valid), 32'd0);
    chk("t5_rst_prod", 32'(product), 32'd0);
    run_op(8'd2, 8'd3, "t5b");
    handoff("t5b");

    // Random stream with random back-pressure; products must arrive in order.
    got_n = 0; sent = 0; cyc = 0;
    while (got_n < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 100) && ($urandom_range(0, 1) == 1);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(16'(a) * 16'(b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_out", 32'(out_valid), 32'd0);
        else chk("rand_product", 32'(product), 32'(q.pop_front()));
        got_n++;
      end
    end
    in_valid = 1'b0;
    chk("rand_count", 32'(got_n), 32'd100);
    chk("rand_leftover", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
